data_mem_arbiter: RTL

- Two-requester arbiter and sequencer that shares the single-port DataMemory between the pipeline MEM stage (port A) and a loader/debug master (port B).
- Latches the winning request and drives the DataMemory control and address/data pins for exactly one cycle.
- Returns read data, or a write acknowledge, to the winner on the following cycle.
- Sits between the requesters and the DataMemory Address/WriteData/MemWrite/MemRead/ReadData pins.

---
 rtl/data_mem_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and sequencer in front of the single-port DataMemory.
// Port A is the pipeline MEM stage and port B is the loader/debug master.
// Each transaction is sequenced as follows:
//   1. The winner's request fields are latched.
//   2. The memory is driven for exactly one ACCESS cycle.
//   3. Completion is reported in the following RESP cycle.
module data_mem_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned FIXED_PRI = 0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ReqA,
    input  logic              ReqB,
    input  logic              WeA,
    input  logic              WeB,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] WDataA,
    input  logic [DATA_W-1:0] WDataB,
    output logic              GntA,
    output logic              GntB,
    output logic              ValidA,
    output logic              ValidB,
    output logic              ErrA,
    output logic              ErrB,
    output logic [DATA_W-1:0] RDataA,
    output logic [DATA_W-1:0] RDataB,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] MemReadData
);

    localparam bit RoundRobin = (FIXED_PRI == 0);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;       // 0 = port A, 1 = port B
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              prefer_b_q, prefer_b_d; // tie goes to B when set
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    logic aligned;
    logic pick_b;

    assign aligned = (addr_q[1:0] == 2'b00);
    // B wins when it is the only requester, or on a tie when B is favoured.
    assign pick_b  = ReqB & (~ReqA | (RoundRobin & prefer_b_q));

    // Next-state: arbitrate in IDLE/RESP, capture read data when leaving ACCESS.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        prefer_b_d = prefer_b_q;
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;

        if (state_q == StAccess) begin
            state_d = StResp;
            if (aligned && !we_q) begin
                if (owner_q) rdata_b_d = MemReadData;
                else         rdata_a_d = MemReadData;
            end
        end else if (ReqA || ReqB) begin
            state_d    = StAccess;
            owner_d    = pick_b;
            we_d       = pick_b ? WeB    : WeA;
            addr_d     = pick_b ? AddrB  : AddrA;
            wdata_d    = pick_b ? WDataB : WDataA;
            prefer_b_d = ~pick_b;
        end else begin
            state_d = StIdle;
        end
    end

    // State and latched-transaction registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            prefer_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            prefer_b_q <= prefer_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    // Outputs are decoded from state, so an async reset kills MemWrite at once.
    always_comb begin
        GntA     = (state_q == StAccess) & ~owner_q;
        GntB     = (state_q == StAccess) &  owner_q;
        ValidA   = (state_q == StResp)   & ~owner_q;
        ValidB   = (state_q == StResp)   &  owner_q;
        ErrA     = ValidA & ~aligned;
        ErrB     = ValidB & ~aligned;
        MemWrite = (state_q == StAccess) & aligned &  we_q;
        MemRead  = (state_q == StAccess) & aligned & ~we_q;
    end

    assign MemAddress   = addr_q;
    assign MemWriteData = wdata_q;
    assign RDataA       = rdata_a_q;
    assign RDataB       = rdata_b_q;

endmodule
